alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Execute-stage controller that sequences the combinational `alu` between decode and memory. It accepts decoded instructions over a valid/ready handshake and registers the operands. It derives the ALU operation and operand-B source from opcode/funct3/funct7, then captures each ALU result into an in-order result FIFO that drains to the memory stage under downstream backpressure. It also provides flush, illegal-opcode reporting and a busy status for the hazard/stall logic.

## Interface
- `N`, 32, datapath width.
- `DEPTH`, 3, result FIFO entries; minimum 2; 3 gives full throughput.
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `in_valid`  in  1  decoded instruction present.
- `in_ready`  out  1  controller accepts this cycle.
- `in_opcode`  in  7  `opcode_t` from `riscv_pkg`.
- `in_funct3`  in  3  funct3.
- `in_funct7`  in  7  funct7.
- `in_reg_a`  in  N  rs1 value.
- `in_reg_b`  in  N  rs2 value.
- `in_imm`  in  N  sign-extended immediate.
- `in_rd`  in  5  destination tag, carried through.
- `flush`  in  1  synchronous kill of all in-flight work.
- `alu_op`  out  4  `alu_op_t` to ALU.
- `alu_a`  out  N  registered operand A.
- `alu_b`  out  N  registered operand B (reg_b or imm).
- `alu_result`  in  N  combinational ALU result, same cycle.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  memory stage accepts.
- `out_result`  out  N  head result.
- `out_rd`  out  5  head destination tag.
- `illegal`  out  1  one-cycle pulse: unsupported opcode consumed.
- `busy`  out  1  E1 occupied or FIFO non-empty.

## Operation
- Accept when `in_valid && in_ready`. `in_ready = !flush && (count + e1_valid) < DEPTH`. `in_ready` has no combinational path from `out_ready`.
- Operation decode at accept:
  - `OPCODE_REG_REG`: B = reg_b. funct3 selects the operation. funct7 = `F7_SUB_SRA` selects SUB for `F3_ADD_SUB` and SRA for `F3_SRL_SRA`. Otherwise ADD/SRL.
  - `OPCODE_REG_IMM`: B = imm. Same funct3 map. funct7 is honoured only for `F3_SRL_SRA`; ADDI never subtracts.
  - `OPCODE_LOAD` / `OPCODE_STORE`: ADD, B = imm (effective address).
  - Any other opcode: accepted, not loaded into E1. `illegal` pulses the next cycle.
- E1 register holds `{alu_op, alu_a, alu_b, rd}`. While `e1_valid`, `{alu_result, rd}` is pushed to the FIFO at the clock edge.
- FIFO is in order, with wrapping read/write pointers mod DEPTH and `count` in 0..DEPTH.
  - Push and pop in the same cycle leave `count` unchanged.
  - Pop on the same cycle as push at count 0 is impossible, since `out_valid` is low.
- FSM `state_t`:
  - IDLE (nothing in flight), RUN (E1 or FIFO occupied), DRAIN (FIFO full, `in_ready` low).
  - IDLE→RUN on accept of a legal op.
  - RUN→DRAIN when `count + e1_valid` reaches DEPTH.
  - DRAIN→RUN on pop.
  - RUN→IDLE when E1 and FIFO are both empty.
  - Any state →IDLE on `flush`.
- `flush`: E1 and FIFO are cleared at the edge. An input offered that cycle is not accepted. Any pending `illegal` pulse is suppressed.

## Timing
- Reset values:
  - `in_ready` = 1 (since count = 0).
  - `out_valid` = 0, `illegal` = 0, `busy` = 0.
  - `alu_op` = ALU_ADD, `alu_a` = 0, `alu_b` = 0.
  - `out_result` = 0, `out_rd` = 0.
  - state = IDLE.
- Reset asserted mid-operation discards all in-flight work immediately, asynchronously.
- Latency: accept at edge k → `alu_*` valid in cycle k+1 → `out_valid` in cycle k+2 when the FIFO was empty.
- Throughput: one op/cycle with DEPTH ≥ 3 and `out_ready` held high.
- `out_result` / `out_rd` are stable while `out_valid && !out_ready`.
- Arithmetic is the ALU's concern. Wrap-around is modulo 2^N; the controller never checks overflow.

## Structure
- Add `alu_op_t` (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND) and `state_t` to `riscv_pkg`. `alu` must also consume `alu_op_t`.
- Reuse the existing `OPCODE_*`, `F3_*` and `F7_*` constants from `riscv_pkg`.
- One sub-module: `result_fifo` (parameterised width/depth, sync push/pop, count).

## Test plan
- REG_REG ADD: A = 5, B = 3, funct7 = `F7_ADD_SRL` → `alu_op` = ADD in cycle k+1; `out_result` = 0x8 with `out_valid` at k+2.
- Op sequence SUB 8−3, SRAI 0xFFFF_FFF0 by 2, STORE 0x2000 + imm 0xFFFF_FFF0, issued back-to-back with `out_ready` = 1:
  - results 0x5, 0xFFFF_FFFC, 0x1FF0, in order;
  - `in_ready` stays high.
- Backpressure: `out_ready` = 0, offer 5 ADDs:
  - exactly 3 accepted, then `in_ready` = 0 and state DRAIN;
  - raise `out_ready` → results pop in issue order, remaining 2 accepted.
- Illegal opcode 7'h7F offered → accepted; `illegal` high exactly one cycle; no FIFO push; `busy` stays 0.
- Flush with FIFO holding 2 and E1 full → next cycle `out_valid` = 0, `busy` = 0, state IDLE; input offered in the flush cycle is not accepted.
- `rst_n` low mid-stream (FIFO holding 2) → all outputs at reset values immediately; after release, the first ADD 0x7FFF_FFFF + 1 → 0x8000_0000.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V encodings plus execute-stage types for the ALU issue path.
// Decode helpers map opcode/funct fields onto an ALU operation.
package riscv_pkg;

    typedef logic [6:0] opcode_t;

    localparam opcode_t OPCODE_LOAD    = 7'b0000011;
    localparam opcode_t OPCODE_REG_IMM = 7'b0010011;
    localparam opcode_t OPCODE_STORE   = 7'b0100011;
    localparam opcode_t OPCODE_REG_REG = 7'b0110011;

    localparam logic [2:0] F3_ADD_SUB = 3'd0;
    localparam logic [2:0] F3_SLL     = 3'd1;
    localparam logic [2:0] F3_SLT     = 3'd2;
    localparam logic [2:0] F3_SLTU    = 3'd3;
    localparam logic [2:0] F3_XOR     = 3'd4;
    localparam logic [2:0] F3_SRL_SRA = 3'd5;
    localparam logic [2:0] F3_OR      = 3'd6;
    localparam logic [2:0] F3_AND     = 3'd7;

    localparam logic [6:0] F7_ADD_SRL = 7'h00;
    localparam logic [6:0] F7_SUB_SRA = 7'h20;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    typedef struct packed {
        logic    legal;
        logic    use_imm;
        alu_op_t op;
    } dec_t;

    // alt is the funct7 alternate bit; sub_ok gates SUB so ADDI never subtracts
    function automatic alu_op_t f3_op(
        input logic [2:0] f3,
        input logic       alt,
        input logic       sub_ok
    );
        alu_op_t r;
        r = ALU_ADD;
        unique case (f3)
            F3_ADD_SUB: r = (alt && sub_ok) ? ALU_SUB : ALU_ADD;
            F3_SLL:     r = ALU_SLL;
            F3_SLT:     r = ALU_SLT;
            F3_SLTU:    r = ALU_SLTU;
            F3_XOR:     r = ALU_XOR;
            F3_SRL_SRA: r = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      r = ALU_OR;
            F3_AND:     r = ALU_AND;
        endcase
        return r;
    endfunction

    function automatic dec_t decode(
        input opcode_t    op,
        input logic [2:0] f3,
        input logic [6:0] f7
    );
        dec_t d;
        d.legal   = 1'b1;
        d.use_imm = 1'b1;
        d.op      = ALU_ADD;
        unique case (1'b1)
            op == OPCODE_REG_REG: begin
                d.use_imm = 1'b0;
                d.op      = f3_op(f3, f7 == F7_SUB_SRA, 1'b1);
            end
            op == OPCODE_REG_IMM: begin
                d.op = f3_op(f3, f7 == F7_SUB_SRA, 1'b0);
            end
            op == OPCODE_LOAD,
            op == OPCODE_STORE: begin
                d.op = ALU_ADD;
            end
            default: begin
                d.legal = 1'b0;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Decode-to-execute issue handshake and execute-to-memory result handshake.
// master is the pipeline side, slave is the issue controller.
interface alu_issue_if
    import riscv_pkg::*;
#(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    opcode_t      in_opcode;
    logic [2:0]   in_funct3;
    logic [6:0]   in_funct7;
    logic [N-1:0] in_reg_a;
    logic [N-1:0] in_reg_b;
    logic [N-1:0] in_imm;
    logic [4:0]   in_rd;

    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_result;
    logic [4:0]   out_rd;

    modport master (
        output in_valid, in_opcode, in_funct3, in_funct7,
        output in_reg_a, in_reg_b, in_imm, in_rd,
        output out_ready,
        input  in_ready, out_valid, out_result, out_rd
    );

    modport slave (
        input  in_valid, in_opcode, in_funct3, in_funct7,
        input  in_reg_a, in_reg_b, in_imm, in_rd,
        input  out_ready,
        output in_ready, out_valid, out_result, out_rd
    );

endinterface

// File: rtl/alu_issue_ctrl_fifo.sv
// In-order result FIFO with wrapping pointers and an occupancy count.
// clr empties it synchronously; the head is read combinationally.
module result_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 3,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign dout = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= din;
                wptr      <= inc(wptr);
            end
            if (pop) begin
                rptr <= inc(rptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue controller: registers decoded operands for the ALU
// and queues each result in order toward the memory stage.
module alu_issue_ctrl
    import riscv_pkg::*;
#(
    parameter int N     = 32,
    parameter int DEPTH = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_issue_if.slave    io,
    input  logic          flush,
    output alu_op_t       alu_op,
    output logic [N-1:0]  alu_a,
    output logic [N-1:0]  alu_b,
    input  logic [N-1:0]  alu_result,
    output logic          illegal,
    output logic          busy
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] FULL = (CW + 1)'(DEPTH);

    dec_t          dec;
    logic          e1_valid;
    logic [4:0]    rd_q;
    logic [CW-1:0] count;
    logic [CW:0]   total;
    logic [CW:0]   nxt_total;
    logic          accept;
    logic          acc_legal;
    logic          pop;
    logic [N+4:0]  head;
    state_t        state_q;

    assign dec = decode(io.in_opcode, io.in_funct3, io.in_funct7);

    // Occupancy counts E1 too, so in_ready never depends on out_ready
    assign total       = {1'b0, count} + {{CW{1'b0}}, e1_valid};
    assign io.in_ready = !flush && (total < FULL);
    assign accept      = io.in_valid && io.in_ready;
    assign acc_legal   = accept && dec.legal;

    assign io.out_valid = count != '0;
    assign pop          = io.out_valid && io.out_ready;
    assign busy         = e1_valid || io.out_valid;

    assign nxt_total = total
                     - {{CW{1'b0}}, pop}
                     + {{CW{1'b0}}, acc_legal};

    assign {io.out_result, io.out_rd} = head;

    result_fifo #(
        .W     (N + 5),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .push  (e1_valid),
        .din   ({alu_result, rd_q}),
        .pop   (pop),
        .dout  (head),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e1_valid <= 1'b0;
            alu_op   <= ALU_ADD;
            alu_a    <= '0;
            alu_b    <= '0;
            rd_q     <= '0;
            illegal  <= 1'b0;
        end else begin
            illegal  <= accept && !dec.legal;
            e1_valid <= !flush && acc_legal;
            if (acc_legal) begin
                alu_op <= dec.op;
                alu_a  <= io.in_reg_a;
                alu_b  <= dec.use_imm ? io.in_imm : io.in_reg_b;
                rd_q   <= io.in_rd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else if (flush) begin
            state_q <= IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (acc_legal) state_q <= RUN;
                end
                RUN: begin
                    if (nxt_total == FULL)    state_q <= DRAIN;
                    else if (nxt_total == '0) state_q <= IDLE;
                end
                DRAIN: begin
                    if (pop) state_q <= RUN;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomised and directed bench for alu_issue_ctrl against a queue model.
// The bench also plays the combinational ALU.
module tb_alu_issue_ctrl;
    import riscv_pkg::*;

    localparam int N     = 32;
    localparam int DEPTH = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    alu_op_t      alu_op;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [N-1:0] alu_result;
    logic         illegal;
    logic         busy;

    alu_issue_if #(.N(N)) bus ();

    alu_issue_ctrl #(.N(N), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .io         (bus),
        .flush      (flush),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .illegal    (illegal),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(
        input alu_op_t op, input logic [31:0] a, input logic [31:0] b
    );
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << b[4:0];
            ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'b0, a < b};
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return 32'h0;
        endcase
    endfunction

    always_comb begin
        alu_result = alu_fn(alu_op, alu_a, alu_b);
    end

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        alu_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
    } item_t;

    item_t       mq[$];
    item_t       me;
    bit          me1;
    bit          mill;
    logic [31:0] popped[$];
    bit          dut_acc;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Instruction semantics straight from the ISA field rules
    task automatic ref_dec(output bit legal, output item_t it);
        logic [6:0] op;
        logic [2:0] f3;
        bit         alt;
        bit         rr;
        op       = bus.in_opcode;
        f3       = bus.in_funct3;
        alt      = bus.in_funct7 == 7'h20;
        rr       = op == 7'h33;
        legal    = 1'b1;
        it.a     = bus.in_reg_a;
        it.b     = rr ? bus.in_reg_b : bus.in_imm;
        it.rd    = bus.in_rd;
        it.op    = ALU_ADD;
        if (op == 7'h33 || op == 7'h13) begin
            case (f3)
                3'd0: it.op = (alt && rr) ? ALU_SUB : ALU_ADD;
                3'd1: it.op = ALU_SLL;
                3'd2: it.op = ALU_SLT;
                3'd3: it.op = ALU_SLTU;
                3'd4: it.op = ALU_XOR;
                3'd5: it.op = alt ? ALU_SRA : ALU_SRL;
                3'd6: it.op = ALU_OR;
                default: it.op = ALU_AND;
            endcase
        end else if (op != 7'h03 && op != 7'h23) begin
            legal = 1'b0;
        end
        it.res = alu_fn(it.op, it.a, it.b);
    endtask

    task automatic step();
        bit    exp_rdy;
        bit    pop_m;
        bit    acc_m;
        bit    legal;
        item_t it;
        int    occ;
        #1;
        occ     = mq.size() + int'(me1);
        exp_rdy = !flush && occ < DEPTH;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        dut_acc = bus.in_valid && bus.in_ready;
        pop_m   = mq.size() != 0 && bus.out_ready;
        acc_m   = bus.in_valid && exp_rdy;
        if (pop_m && bus.out_valid) popped.push_back(bus.out_result);
        ref_dec(legal, it);
        @(posedge clk);
        if (flush) begin
            mq.delete();
            me1  = 1'b0;
            mill = 1'b0;
        end else begin
            if (pop_m) void'(mq.pop_front());
            if (me1) mq.push_back(me);
            me1  = 1'b0;
            mill = 1'b0;
            if (acc_m) begin
                if (legal) begin
                    me  = it;
                    me1 = 1'b1;
                end else begin
                    mill = 1'b1;
                end
            end
        end
        @(negedge clk);
        occ = mq.size() + int'(me1);
        chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("out_result", bus.out_result, mq[0].res);
            chk("out_rd", 32'(bus.out_rd), 32'(mq[0].rd));
        end
        chk("illegal", 32'(illegal), 32'(mill));
        chk("busy", 32'(busy), 32'(occ != 0));
        chk("state", 32'(dut.state_q),
            32'(occ == 0 ? IDLE : (occ == DEPTH ? DRAIN : RUN)));
        if (me1) begin
            chk("alu_op", 32'(alu_op), 32'(me.op));
            chk("alu_a", alu_a, me.a);
            chk("alu_b", alu_b, me.b);
        end
    endtask

    task automatic offer(input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm,
                         input logic [4:0] rd);
        bus.in_valid  = 1'b1;
        bus.in_opcode = op;
        bus.in_funct3 = f3;
        bus.in_funct7 = f7;
        bus.in_reg_a  = a;
        bus.in_reg_b  = b;
        bus.in_imm    = imm;
        bus.in_rd     = rd;
    endtask

    task automatic add_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
        offer(OPCODE_REG_REG, F3_ADD_SUB, F7_ADD_SRL, a, b, 32'h0, rd);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_illegal"}, 32'(illegal), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_alu_op"}, 32'(alu_op), 32'(ALU_ADD));
        chk({tag, "_alu_a"}, alu_a, 32'h0);
        chk({tag, "_alu_b"}, alu_b, 32'h0);
        chk({tag, "_out_result"}, bus.out_result, 32'h0);
        chk({tag, "_out_rd"}, 32'(bus.out_rd), 32'd0);
        chk({tag, "_state"}, 32'(dut.state_q), 32'(IDLE));
    endtask

    task automatic accept_n(input int n);
        int acc = 0;
        for (int c = 0; c < 20 && acc < n; c++) begin
            add_op(32'(c + 1), 32'(c + 2), 5'(c + 1));
            step();
            if (dut_acc) acc++;
        end
        bus.in_valid = 1'b0;
        chk("accept_n", 32'(acc), 32'(n));
    endtask

    initial begin
        int       acc;
        int       sel;
        logic [6:0] op;
        logic [6:0] f7;
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        offer(7'h0, 3'h0, 7'h0, 32'h0, 32'h0, 32'h0, 5'h0);
        bus.in_valid  = 1'b0;
        me1  = 1'b0;
        mill = 1'b0;
        #12;
        chk_reset("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // ADD 5 + 3
        add_op(32'd5, 32'd3, 5'd1);
        step();
        bus.in_valid = 1'b0;
        chk("add_op_k1", 32'(alu_op), 32'(ALU_ADD));
        chk("add_a_k1", alu_a, 32'd5);
        chk("add_b_k1", alu_b, 32'd3);
        chk("add_nv_k1", 32'(bus.out_valid), 32'd0);
        step();
        chk("add_v_k2", 32'(bus.out_valid), 32'd1);
        chk("add_res_k2", bus.out_result, 32'h8);
        step();

        // back-to-back SUB, SRAI, STORE
        popped.delete();
        offer(OPCODE_REG_REG, F3_ADD_SUB, F7_SUB_SRA,
              32'd8, 32'd3, 32'h0, 5'd2);
        step();
        chk("b2b_acc0", 32'(dut_acc), 32'd1);
        offer(OPCODE_REG_IMM, F3_SRL_SRA, F7_SUB_SRA,
              32'hFFFF_FFF0, 32'h0, 32'd2, 5'd3);
        step();
        chk("b2b_acc1", 32'(dut_acc), 32'd1);
        offer(OPCODE_STORE, F3_SLT, 7'h0,
              32'h2000, 32'h55, 32'hFFFF_FFF0, 5'd4);
        step();
        chk("b2b_acc2", 32'(dut_acc), 32'd1);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("b2b_n", 32'(popped.size()), 32'd3);
        if (popped.size() == 3) begin
            chk("b2b_r0", popped[0], 32'h5);
            chk("b2b_r1", popped[1], 32'hFFFF_FFFC);
            chk("b2b_r2", popped[2], 32'h1FF0);
        end

        // backpressure
        popped.delete();
        bus.out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            add_op(32'(100 + acc), 32'(acc), 5'(acc + 1));
            step();
            if (dut_acc) acc++;
        end
        chk("bp_acc3", 32'(acc), 32'd3);
        chk("bp_ready0", 32'(bus.in_ready), 32'd0);
        chk("bp_drain", 32'(dut.state_q), 32'(DRAIN));
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && acc < 5; c++) begin
            add_op(32'(100 + acc), 32'(acc), 5'(acc + 1));
            step();
            if (dut_acc) acc++;
        end
        bus.in_valid = 1'b0;
        chk("bp_acc5", 32'(acc), 32'd5);
        for (int i = 0; i < 6; i++) step();
        chk("bp_n", 32'(popped.size()), 32'd5);
        for (int i = 0; i < popped.size() && i < 5; i++) begin
            chk("bp_order", popped[i], 32'(100 + 2 * i));
        end

        // illegal opcode
        offer(7'h7F, 3'h0, 7'h0, 32'h1, 32'h2, 32'h3, 5'd9);
        step();
        bus.in_valid = 1'b0;
        chk("ill_acc", 32'(dut_acc), 32'd1);
        chk("ill_pulse", 32'(illegal), 32'd1);
        chk("ill_busy", 32'(busy), 32'd0);
        chk("ill_nopush", 32'(bus.out_valid), 32'd0);
        step();
        chk("ill_end", 32'(illegal), 32'd0);
        chk("ill_busy2", 32'(busy), 32'd0);

        // flush with FIFO holding 2 and E1 full
        bus.out_ready = 1'b0;
        accept_n(3);
        add_op(32'h11, 32'h22, 5'd7);
        flush = 1'b1;
        step();
        chk("fl_noacc", 32'(dut_acc), 32'd0);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl_out_valid", 32'(bus.out_valid), 32'd0);
        chk("fl_busy", 32'(busy), 32'd0);
        chk("fl_state", 32'(dut.state_q), 32'(IDLE));
        bus.out_ready = 1'b1;
        step();

        // asynchronous reset mid-stream
        bus.out_ready = 1'b0;
        accept_n(2);
        step();
        chk("mid_cnt", 32'(bus.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("arst");
        mq.delete();
        me1  = 1'b0;
        mill = 1'b0;
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        add_op(32'h7FFF_FFFF, 32'h1, 5'd5);
        step();
        bus.in_valid = 1'b0;
        step();
        chk("wrap_res", bus.out_result, 32'h8000_0000);
        step();

        // random traffic
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) != 0) begin
                sel = $urandom_range(0, 5);
                case (sel)
                    0, 1: op = OPCODE_REG_REG;
                    2:    op = OPCODE_REG_IMM;
                    3:    op = OPCODE_LOAD;
                    4:    op = OPCODE_STORE;
                    default: op = 7'($urandom);
                endcase
                f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'($urandom);
                offer(op, 3'($urandom), f7, $urandom, $urandom,
                      $urandom, 5'($urandom));
            end else begin
                bus.in_valid = 1'b0;
            end
            bus.out_ready = $urandom_range(0, 2) != 0;
            flush = $urandom_range(0, 29) == 0;
            step();
        end
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("final_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
